// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Oversampling asynchronous serial receiver for 8N1-style frames: one start
// bit, DATA_BITS data bits sent LSB first, one stop bit. Each serial bit lasts
// CLKS_PER_BIT clock cycles. The receiver finds the middle of the start bit and
// then samples every later bit one bit-period apart, so every sample lands
// mid-bit. Its outputs feed the UART word-packing buffer in the BPSK receive
// path directly: data_out -> data_in, data_valid -> write.
//
// Parameters
//   CLKS_PER_BIT   clk cycles per serial bit (>= 4)
//   DATA_BITS      data bits per frame (1..16), must match the packer width
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          synchronous reset, active low
//   rx             asynchronous serial line, idle high
//   data_out       last correctly framed word, held until the next good frame
//   data_valid     1-cycle pulse, data_out was updated this cycle
//   framing_error  1-cycle pulse, the stop bit was sampled low
//   busy           high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 busy
);

   // Counter widths. The tick counter only ever needs to reach
   // CLKS_PER_BIT-1; the bit index needs to count up to DATA_BITS.
   localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W  = (DATA_BITS > 0) ? $clog2(DATA_BITS + 1) : 1;

   // Tick values at which the line is sampled. The start bit is checked at
   // its midpoint; after that, sampling every full bit period keeps every
   // later sample centred in its bit.
   localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_END = TICK_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t               state;
   state_t               state_next;

   logic                 rx_meta;
   logic                 rx_s;

   logic [TICK_W-1:0]    tick;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_next;

   logic                 tick_clr;
   logic                 tick_inc;
   logic                 shift_en;
   logic                 load_word;
   logic                 flag_error;

   // Two-flop synchroniser for the asynchronous line. Both flops reset to the
   // idle level so that leaving reset never looks like a start edge. Nothing
   // downstream ever looks at rx directly, only at rx_s.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // State register of the receive FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode. The block only raises strobes; the
   // counters, shift register and output pulses are all updated in the
   // datapath process below. A failed start sample is treated as a glitch
   // and dropped silently. A low stop bit goes to BREAK, which waits for the
   // line to return high, so a line stuck low cannot start a run of
   // phantom frames.
   always_comb begin
      state_next = state;
      tick_clr   = 1'b0;
      tick_inc   = 1'b0;
      shift_en   = 1'b0;
      load_word  = 1'b0;
      flag_error = 1'b0;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
            end
         end

         START: begin
            if (tick == TICK_MID) begin
               state_next = rx_s ? IDLE : DATA;
            end else begin
               tick_inc = 1'b1;
            end
         end

         DATA: begin
            if (tick == TICK_END) begin
               shift_en = 1'b1;
               tick_clr = 1'b1;
               if (bit_idx == IDX_LAST) begin
                  state_next = STOP;
               end
            end else begin
               tick_inc = 1'b1;
            end
         end

         STOP: begin
            if (tick == TICK_END) begin
               if (rx_s) begin
                  load_word  = 1'b1;
                  state_next = IDLE;
               end else begin
                  flag_error = 1'b1;
                  state_next = BREAK;
               end
            end else begin
               tick_inc = 1'b1;
            end
         end

         BREAK: begin
            if (rx_s) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The shift register fills from the top: each new bit enters at the MSB
   // and older bits move down. Because the line is sent LSB first, the first
   // bit received reaches bit 0 once all DATA_BITS samples are in.
   always_comb begin
      shift_next                = shift_reg >> 1;
      shift_next[DATA_BITS-1]   = rx_s;
   end

   // Datapath: tick and bit counters, shift register, and the registered
   // output pulses. Both counters restart on every state change, so each
   // state measures time from its own entry. Returning to IDLE at the stop
   // bit's midpoint leaves half a bit of margin, which lets a back-to-back
   // start edge be caught with no dead bit in between.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick          <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         data_out      <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         if (state_next != state) begin
            tick    <= '0;
            bit_idx <= '0;
         end else begin
            if (tick_clr) begin
               tick <= '0;
            end else if (tick_inc) begin
               tick <= tick + 1'b1;
            end
            if (shift_en) begin
               bit_idx <= bit_idx + 1'b1;
            end
         end

         if (shift_en) begin
            shift_reg <= shift_next;
         end

         if (load_word) begin
            data_out <= shift_reg;
         end

         data_valid    <= load_word;
         framing_error <= flag_error;
      end
   end

   // busy is a plain decode of the state, so it drops the same cycle the
   // FSM returns to IDLE.
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. It drives two receivers: an 8-bit one for
// most tests and a 4-bit one whose nibbles are packed into a 16-bit word, the
// same way the downstream packer does. Frames are built bit by bit from their
// intended values. Results are compared against what a correct receiver must
// produce: one word per good frame, one error pulse per bad stop bit, nothing
// for glitches or aborted frames.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int C = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       framing_error;
   logic       busy;

   logic       rx4;
   logic [3:0] data_out4;
   logic       data_valid4;
   logic       framing_error4;
   logic       busy4;

   int         checks = 0;
   int         passes = 0;
   int         cycle  = 0;
   int         fe_cnt = 0;
   int         fe4_cnt = 0;
   int         both_cnt = 0;
   logic [7:0] vq[$];
   int         vt[$];
   logic [3:0] nq[$];

   uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .framing_error (framing_error),
      .busy          (busy)
   );

   uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(4)) dut4 (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx4),
      .data_out      (data_out4),
      .data_valid    (data_valid4),
      .framing_error (framing_error4),
      .busy          (busy4)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Monitor: samples on the falling edge, away from the active edge, and
   // records every output pulse together with its cycle number.
   always @(negedge clk) begin
      cycle <= cycle + 1;
      if (data_valid) begin
         vq.push_back(data_out);
         vt.push_back(cycle);
      end
      if (framing_error) fe_cnt <= fe_cnt + 1;
      if (data_valid && framing_error) both_cnt <= both_cnt + 1;
      if (data_valid4) nq.push_back(data_out4);
      if (framing_error4) fe4_cnt <= fe4_cnt + 1;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input bit narrow, input logic v);
      if (narrow) rx4 = v;
      else        rx  = v;
   endtask

   // One complete frame: start bit, nbits data bits LSB first, stop bit,
   // then the line is left idle high.
   task automatic apply_stimulus(input bit narrow, input int nbits, input logic [15:0] w,
                                 input logic stop_bit);
      drive(narrow, 1'b0);
      hold(C);
      for (int i = 0; i < nbits; i++) begin
         drive(narrow, w[i]);
         hold(C);
      end
      drive(narrow, stop_bit);
      hold(C);
      drive(narrow, 1'b1);
   endtask

   initial begin
      int         vb;
      int         fb;
      int         nb;
      logic [7:0] expq[$];
      logic [7:0] w;
      logic [15:0] packed_word;

      rx    = 1'b1;
      rx4   = 1'b1;
      rst_n = 1'b0;
      hold(3);

      // Reset state
      check_output("reset_data_out", 32'(data_out), 32'h0);
      check_output("reset_data_valid", 32'(data_valid), 32'h0);
      check_output("reset_framing_error", 32'(framing_error), 32'h0);
      check_output("reset_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      hold(4);

      // 1: good frame 0xA5
      $display("[TB] frame 0xA5");
      vb = vq.size(); fb = fe_cnt;
      apply_stimulus(1'b0, 8, 16'h00A5, 1'b1);
      hold(20);
      check_output("t1_count", 32'(vq.size() - vb), 32'd1);
      if (vq.size() > vb) check_output("t1_value", 32'(vq[vb]), 32'hA5);
      check_output("t1_ferr", 32'(fe_cnt - fb), 32'd0);
      check_output("t1_busy", 32'(busy), 32'h0);
      check_output("t1_hold", 32'(data_out), 32'hA5);

      // 2: 4-clock glitch is rejected
      $display("[TB] start glitch");
      vb = vq.size(); fb = fe_cnt;
      rx = 1'b0;
      hold(4);
      rx = 1'b1;
      hold(40);
      check_output("t2_count", 32'(vq.size() - vb), 32'd0);
      check_output("t2_ferr", 32'(fe_cnt - fb), 32'd0);
      check_output("t2_busy", 32'(busy), 32'h0);

      // 3: bad stop bit, line held low, then recovery with 0x81
      $display("[TB] framing error and recovery");
      vb = vq.size(); fb = fe_cnt;
      apply_stimulus(1'b0, 8, 16'h003C, 1'b0);
      rx = 1'b0;
      hold(40);
      rx = 1'b1;
      hold(2 * C);
      check_output("t3_ferr", 32'(fe_cnt - fb), 32'd1);
      check_output("t3_count", 32'(vq.size() - vb), 32'd0);
      check_output("t3_data_kept", 32'(data_out), 32'hA5);
      check_output("t3_busy", 32'(busy), 32'h0);
      apply_stimulus(1'b0, 8, 16'h0081, 1'b1);
      hold(20);
      check_output("t3_next_count", 32'(vq.size() - vb), 32'd1);
      if (vq.size() > vb) check_output("t3_next_value", 32'(vq[vb]), 32'h81);

      // 4: three back-to-back frames, one frame time apart
      $display("[TB] back-to-back frames");
      vb = vq.size();
      apply_stimulus(1'b0, 8, 16'h0000, 1'b1);
      apply_stimulus(1'b0, 8, 16'h00FF, 1'b1);
      apply_stimulus(1'b0, 8, 16'h0055, 1'b1);
      hold(20);
      check_output("t4_count", 32'(vq.size() - vb), 32'd3);
      if (vq.size() >= vb + 3) begin
         check_output("t4_v0", 32'(vq[vb]), 32'h00);
         check_output("t4_v1", 32'(vq[vb+1]), 32'hFF);
         check_output("t4_v2", 32'(vq[vb+2]), 32'h55);
         check_output("t4_gap01", 32'(vt[vb+1] - vt[vb]), 32'd160);
         check_output("t4_gap12", 32'(vt[vb+2] - vt[vb+1]), 32'd160);
      end

      // 5: reset in the middle of the 4th data bit
      $display("[TB] mid-frame reset");
      vb = vq.size(); fb = fe_cnt;
      w = 8'hB6;
      rx = 1'b0;
      hold(C);
      for (int i = 0; i < 3; i++) begin
         rx = w[i];
         hold(C);
      end
      rx = w[3];
      hold(C / 2);
      check_output("t5_busy_mid", 32'(busy), 32'h1);
      rst_n = 1'b0;
      hold(1);
      rst_n = 1'b1;
      rx = 1'b1;
      check_output("t5_data_out", 32'(data_out), 32'h0);
      check_output("t5_busy", 32'(busy), 32'h0);
      check_output("t5_valid", 32'(data_valid), 32'h0);
      hold(3 * C);
      check_output("t5_no_pulse", 32'(vq.size() - vb), 32'd0);
      check_output("t5_no_ferr", 32'(fe_cnt - fb), 32'd0);
      apply_stimulus(1'b0, 8, 16'h007E, 1'b1);
      hold(20);
      check_output("t5_next_count", 32'(vq.size() - vb), 32'd1);
      if (vq.size() > vb) check_output("t5_next_value", 32'(vq[vb]), 32'h7E);

      // Randomised frames with random idle gaps, some back-to-back
      $display("[TB] random frames");
      vb = vq.size(); fb = fe_cnt;
      for (int k = 0; k < 16; k++) begin
         w = 8'($urandom_range(0, 255));
         expq.push_back(w);
         apply_stimulus(1'b0, 8, {8'h00, w}, 1'b1);
         hold($urandom_range(0, 20));
      end
      hold(40);
      check_output("rand_count", 32'(vq.size() - vb), 32'(expq.size()));
      for (int k = 0; k < expq.size(); k++) begin
         if (vb + k < vq.size()) check_output($sformatf("rand_v%0d", k), 32'(vq[vb+k]), 32'(expq[k]));
      end
      check_output("rand_ferr", 32'(fe_cnt - fb), 32'd0);

      // 6: 4-bit receiver, nibbles packed first-in-most-significant
      $display("[TB] nibble packing");
      nb = nq.size();
      apply_stimulus(1'b1, 4, 16'h0001, 1'b1);
      apply_stimulus(1'b1, 4, 16'h0002, 1'b1);
      apply_stimulus(1'b1, 4, 16'h0003, 1'b1);
      apply_stimulus(1'b1, 4, 16'h0004, 1'b1);
      hold(20);
      check_output("t6_count", 32'(nq.size() - nb), 32'd4);
      packed_word = '0;
      for (int k = nb; k < nq.size(); k++) packed_word = {packed_word[11:0], nq[k]};
      check_output("t6_packed", 32'(packed_word), 32'h1234);
      check_output("t6_ferr", 32'(fe4_cnt), 32'd0);

      check_output("never_both_pulses", 32'(both_cnt), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
